tuple_field_sequencer: RTL and testbench

Serializes a small table of constant-valued, narrow-width scalar tuple fields onto one valid/ready output stream. Sits between the constant tuple datapath (ten scalar fields, 2–4 bits each) and a single shared downstream consumer. Fields are emitted in index order, skipping masked ones with no bubble cycles. A config port rewrites field values and widths while the block is idle.

---
 rtl/tuple_seq_pkg.sv | 33 +++
 rtl/tuple_field_pick.sv | 24 ++
 rtl/tuple_field_sequencer.sv | 110 +++++++++++
 tb/tb_tuple_field_sequencer.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tuple_seq_pkg.sv
// Shared constants, state encoding and power-on field table for the tuple field sequencer.
package tuple_seq_pkg;

    localparam int N_FIELDS = 10;
    localparam int VAL_W    = 4;
    localparam int IDX_W    = 4;
    localparam int WID_W    = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [VAL_W-1:0] RST_VAL [N_FIELDS] = '{
        4'd7, 4'd8, 4'd9, 4'd10, 4'd7, 4'd6, 4'd3, 4'd3, 4'd7, 4'd5
    };

    localparam logic [WID_W-1:0] RST_WID [N_FIELDS] = '{
        3'd3, 3'd4, 3'd4, 3'd4, 3'd3, 3'd3, 3'd2, 3'd2, 3'd3, 3'd3
    };

    function automatic logic [VAL_W-1:0] low_bits(input logic [VAL_W-1:0] v,
                                                  input logic [WID_W-1:0] w);
        logic [VAL_W-1:0] r;
        r = '0;
        for (int i = 0; i < VAL_W; i++) begin
            if (i < int'(w)) r[i] = v[i];
        end
        return r;
    endfunction

endpackage

// File: rtl/tuple_field_pick.sv
// Finds the lowest enabled field above (or, when incl is set, at or above) a base index.
module tuple_field_pick
    import tuple_seq_pkg::*;
(
    input  logic [N_FIELDS-1:0] mask,
    input  logic [IDX_W-1:0]    base,
    input  logic                incl,
    output logic [IDX_W-1:0]    idx,
    output logic                found
);

    // Descending scan so the lowest qualifying index is the last one written.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int i = N_FIELDS - 1; i >= 0; i--) begin
            if (mask[i] && ((int'(base) < i) || (incl && int'(base) == i))) begin
                idx   = IDX_W'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tuple_field_sequencer.sv
// Streams enabled tuple fields in index order over valid/ready; field table is
// rewritable through the config port while idle.
//
//   state | meaning
//   IDLE  | waiting for start; config writes accepted
//   SEND  | presenting table[cur_idx] until the consumer takes it
//   DONE  | one-cycle done pulse, then back to IDLE
module tuple_field_sequencer
    import tuple_seq_pkg::*;
(
    input  logic                clock,
    input  logic                reset_n,
    input  logic                start,
    input  logic [N_FIELDS-1:0] field_en,
    input  logic                cfg_we,
    input  logic [IDX_W-1:0]    cfg_idx,
    input  logic [VAL_W-1:0]    cfg_val,
    input  logic [WID_W-1:0]    cfg_w,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [IDX_W-1:0]    out_idx,
    output logic [VAL_W-1:0]    out_data,
    output logic [WID_W-1:0]    out_width,
    output logic                busy,
    output logic                done,
    output logic                cfg_err
);

    state_t              state;
    logic [N_FIELDS-1:0] mask_q;
    logic [IDX_W-1:0]    cur_idx;
    logic [VAL_W-1:0]    tbl_val [N_FIELDS];
    logic [WID_W-1:0]    tbl_wid [N_FIELDS];

    logic [N_FIELDS-1:0] pick_mask;
    logic [IDX_W-1:0]    pick_base;
    logic                pick_incl;
    logic [IDX_W-1:0]    pick_idx;
    logic                pick_found;
    logic                cfg_ok;

    // In IDLE the finder looks at the incoming mask from index 0; otherwise it
    // looks past the field currently on the bus.
    assign pick_incl = (state == IDLE);
    assign pick_mask = pick_incl ? field_en : mask_q;
    assign pick_base = pick_incl ? '0 : cur_idx;

    tuple_field_pick u_pick (
        .mask  (pick_mask),
        .base  (pick_base),
        .incl  (pick_incl),
        .idx   (pick_idx),
        .found (pick_found)
    );

    assign cfg_ok = (state == IDLE) && (int'(cfg_idx) < N_FIELDS) &&
                    (cfg_w != '0) && (int'(cfg_w) <= VAL_W);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N_FIELDS; i++) begin
                tbl_val[i] <= RST_VAL[i];
                tbl_wid[i] <= RST_WID[i];
            end
        end else if (cfg_we && cfg_ok) begin
            tbl_val[cfg_idx] <= low_bits(cfg_val, cfg_w);
            tbl_wid[cfg_idx] <= cfg_w;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            mask_q  <= '0;
            cur_idx <= '0;
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= cfg_we && !cfg_ok;
            case (state)
                IDLE: begin
                    if (start) begin
                        mask_q <= field_en;
                        if (pick_found) begin
                            cur_idx <= pick_idx;
                            state   <= SEND;
                        end else begin
                            state <= DONE;
                        end
                    end
                end
                SEND: begin
                    if (out_ready) begin
                        if (pick_found) cur_idx <= pick_idx;
                        else            state   <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign out_valid = (state == SEND);
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign out_idx   = cur_idx;
    assign out_data  = out_valid ? tbl_val[cur_idx] : '0;
    assign out_width = out_valid ? tbl_wid[cur_idx] : '0;

endmodule

// File: tb/tb_tuple_field_sequencer.sv
// Randomized bench for tuple_field_sequencer against a table-and-queue reference model.
module tb_tuple_field_sequencer;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       start;
    logic [9:0] field_en;
    logic       cfg_we;
    logic [3:0] cfg_idx;
    logic [3:0] cfg_val;
    logic [2:0] cfg_w;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_idx;
    logic [3:0] out_data;
    logic [2:0] out_width;
    logic       busy;
    logic       done;
    logic       cfg_err;

    int n_tests = 0;
    int n_fail  = 0;

    logic [3:0] m_val [10];
    logic [2:0] m_wid [10];

    always #5 clock = ~clock;

    tuple_field_sequencer dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .start     (start),
        .field_en  (field_en),
        .cfg_we    (cfg_we),
        .cfg_idx   (cfg_idx),
        .cfg_val   (cfg_val),
        .cfg_w     (cfg_w),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_data  (out_data),
        .out_width (out_width),
        .busy      (busy),
        .done      (done),
        .cfg_err   (cfg_err)
    );

    function automatic bit model_legal(input int ci, input int cw);
        return (ci >= 0) && (ci < 10) && (cw >= 1) && (cw <= 4);
    endfunction

    task automatic model_reset();
        int rv [10] = '{7, 8, 9, 10, 7, 6, 3, 3, 7, 5};
        int rw [10] = '{3, 4, 4, 4, 3, 3, 2, 2, 3, 3};
        for (int i = 0; i < 10; i++) begin
            m_val[i] = 4'(rv[i]);
            m_wid[i] = 3'(rw[i]);
        end
    endtask

    task automatic model_write(input int ci, input int cv, input int cw);
        if (model_legal(ci, cw)) begin
            m_val[ci] = 4'(cv % (1 << cw));
            m_wid[ci] = 3'(cw);
        end
    endtask

    // Assumes entry at a negedge with the DUT idle.
    task automatic do_cfg(input int ci, input int cv, input int cw);
        bit exp_err;
        exp_err = !model_legal(ci, cw);
        cfg_we  = 1'b1;
        cfg_idx = 4'(ci);
        cfg_val = 4'(cv);
        cfg_w   = 3'(cw);
        @(posedge clock);
        @(negedge clock);
        cfg_we = 1'b0;
        n_tests++;
        if (cfg_err !== exp_err) begin
            n_fail++;
            $display("FAIL cfg_err idx=%0d w=%0d: got %0b expected %0b", ci, cw, cfg_err, exp_err);
        end
        model_write(ci, cv, cw);
        @(posedge clock);
        @(negedge clock);
        n_tests++;
        if (cfg_err !== 1'b0) begin
            n_fail++;
            $display("FAIL cfg_err_pulse: got %0b expected 0", cfg_err);
        end
    endtask

    // mode 0: ready always; 1: random ready; 2: ready low 3 cycles while idx 2 shown
    task automatic run_seq(input logic [9:0] en, input int mode, input bit cfg_now,
                           input int ci, input int cv, input int cw, input bit busy_wr);
        int  exp_q [$];
        int  ptr, cyc, stall, e;
        bit  fin, rdy;
        start    = 1'b1;
        field_en = en;
        if (cfg_now) begin
            cfg_we  = 1'b1;
            cfg_idx = 4'(ci);
            cfg_val = 4'(cv);
            cfg_w   = 3'(cw);
        end
        @(posedge clock);
        @(negedge clock);
        start  = 1'b0;
        cfg_we = 1'b0;
        if (cfg_now) begin
            n_tests++;
            if (cfg_err !== !model_legal(ci, cw)) begin
                n_fail++;
                $display("FAIL cfg_with_start: got %0b expected %0b", cfg_err, !model_legal(ci, cw));
            end
            model_write(ci, cv, cw);
        end
        for (int i = 0; i < 10; i++) if (en[i]) exp_q.push_back(i);
        ptr = 0; cyc = 1; stall = 0; fin = 1'b0;
        while (!fin && cyc < 200) begin
            cfg_we = 1'b0;
            if (busy_wr && cyc == 2) begin
                n_tests++;
                if (cfg_err !== 1'b1) begin
                    n_fail++;
                    $display("FAIL cfg_err_busy: got %0b expected 1", cfg_err);
                end
            end
            if (ptr < exp_q.size()) begin
                e = exp_q[ptr];
                n_tests++;
                if (out_valid !== 1'b1 || busy !== 1'b1 || done !== 1'b0) begin
                    n_fail++;
                    $display("FAIL beat_flags cyc=%0d: got v=%0b b=%0b d=%0b expected v=1 b=1 d=0",
                             cyc, out_valid, busy, done);
                end
                n_tests++;
                if (out_idx !== 4'(e)) begin
                    n_fail++;
                    $display("FAIL out_idx cyc=%0d: got %0d expected %0d", cyc, out_idx, e);
                end
                n_tests++;
                if (out_data !== m_val[e] || out_width !== m_wid[e]) begin
                    n_fail++;
                    $display("FAIL out_data/width idx=%0d: got %0d/%0d expected %0d/%0d",
                             e, out_data, out_width, m_val[e], m_wid[e]);
                end
                if (mode == 1) rdy = 1'($urandom_range(0, 1));
                else if (mode == 2 && e == 2 && stall < 3) begin
                    rdy = 1'b0;
                    stall++;
                end else rdy = 1'b1;
                if (busy_wr && cyc == 1) begin
                    cfg_we = 1'b1; cfg_idx = 4'd0; cfg_val = 4'd0; cfg_w = 3'd4;
                end
                out_ready = rdy;
                @(posedge clock);
                if (rdy) ptr++;
            end else begin
                n_tests++;
                if (out_valid !== 1'b0 || done !== 1'b1 || busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL done_flags cyc=%0d: got v=%0b d=%0b b=%0b expected v=0 d=1 b=1",
                             cyc, out_valid, done, busy);
                end
                if (mode != 1) begin
                    n_tests++;
                    if (cyc != exp_q.size() + 1 + stall) begin
                        n_fail++;
                        $display("FAIL done_cycle: got %0d expected %0d", cyc, exp_q.size() + 1 + stall);
                    end
                end
                fin = 1'b1;
                out_ready = 1'($urandom_range(0, 1));
                @(posedge clock);
            end
            @(negedge clock);
            cyc++;
        end
        cfg_we = 1'b0;
        if (!fin) begin
            n_tests++;
            n_fail++;
            $display("FAIL seq_timeout: got no done within %0d cycles expected done", cyc);
        end
        n_tests++;
        if (busy !== 1'b0 || done !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL after_done: got b=%0b d=%0b v=%0b expected all 0", busy, done, out_valid);
        end
        out_ready = 1'b1;
    endtask

    task automatic test_reset();
        n_tests++;
        if ({out_valid, busy, done, cfg_err} !== 4'b0 || out_idx !== 4'd0 ||
            out_data !== 4'd0 || out_width !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got v=%0b b=%0b d=%0b e=%0b idx=%0d data=%0d w=%0d expected all 0",
                     out_valid, busy, done, cfg_err, out_idx, out_data, out_width);
        end
    endtask

    task automatic test_full();        run_seq(10'h3FF, 0, 0, 0, 0, 0, 0); endtask
    task automatic test_gap();         run_seq(10'h2FF, 0, 0, 0, 0, 0, 0); endtask
    task automatic test_empty();       run_seq(10'h000, 0, 0, 0, 0, 0, 0); endtask
    task automatic test_backpressure(); run_seq(10'h3FF, 2, 0, 0, 0, 0, 0); endtask

    task automatic test_cfg();
        do_cfg(6, 15, 2);
        do_cfg(3, 11, 3);
        do_cfg(0, 5, 0);
        do_cfg(12, 5, 3);
        do_cfg(1, 5, 5);
        run_seq(10'h3FF, 0, 0, 0, 0, 0, 0);
        run_seq(10'h3FF, 0, 0, 0, 0, 0, 1);
        run_seq(10'h3FF, 0, 1, 5, 14, 1, 0);
    endtask

    task automatic test_random();
        for (int k = 0; k < 20; k++) begin
            do_cfg(int'($urandom_range(0, 12)), int'($urandom_range(0, 15)), int'($urandom_range(0, 5)));
            run_seq(10'($urandom), 1, 0, 0, 0, 0, 0);
        end
    endtask

    task automatic test_reset_mid();
        int  guard;
        do_cfg(4, 1, 1);
        start    = 1'b1;
        field_en = 10'h3FF;
        out_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        guard = 0;
        while (!(out_valid === 1'b1 && out_idx === 4'd4) && guard < 20) begin
            @(posedge clock);
            @(negedge clock);
            guard++;
        end
        n_tests++;
        if (guard >= 20) begin
            n_fail++;
            $display("FAIL reset_mid_reach: got idx %0d expected 4", out_idx);
        end
        #1 reset_n = 1'b0;
        #1;
        n_tests++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_flags: got v=%0b b=%0b d=%0b expected all 0", out_valid, busy, done);
        end
        @(negedge clock);
        reset_n = 1'b1;
        model_reset();
        @(negedge clock);
        run_seq(10'h3FF, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        reset_n   = 1'b0;
        start     = 1'b0;
        field_en  = '0;
        cfg_we    = 1'b0;
        cfg_idx   = '0;
        cfg_val   = '0;
        cfg_w     = '0;
        out_ready = 1'b1;
        model_reset();
        repeat (3) @(negedge clock);
        test_reset();
        reset_n = 1'b1;
        @(negedge clock);
        test_full();
        test_gap();
        test_empty();
        test_backpressure();
        test_cfg();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
